// File: rtl/pc_sequencer.sv
// Program-counter unit: owns the PC, the one-hot phase rotator and a circular
// return-address stack, and selects the next PC at fetch and at write-back.
module pc_sequencer #(
    parameter int PC_W      = 12,
    parameter int DATA_W    = 16,
    parameter int NPHASE    = 5,
    parameter int RAS_DEPTH = 4,
    parameter int RESET_PC  = 0
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           stall,
    input  logic [15:0]                    instr,
    input  logic [DATA_W-1:0]              result,
    input  logic                           cond,
    output logic [NPHASE-1:0]              phase,
    output logic [PC_W-1:0]                pc,
    output logic                           pc_we,
    output logic [$clog2(RAS_DEPTH+1)-1:0] ras_count,
    output logic                           ras_err,
    output logic                           halted
);
    localparam int CNT_W = $clog2(RAS_DEPTH + 1);
    localparam int PTR_W = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;

    localparam logic [4:0] OP_JMP  = 5'b10100;
    localparam logic [4:0] OP_BC   = 5'b10101;
    localparam logic [4:0] OP_CALL = 5'b10110;
    localparam logic [4:0] OP_JR   = 5'b10111;
    localparam logic [4:0] OP_RET  = 5'b11000;
    localparam logic [4:0] OP_HLT  = 5'b11111;

    // Handshake: none; stall=1 is a level hold that freezes every state element.
    logic [PC_W-1:0]   ras_mem [RAS_DEPTH];
    logic [PTR_W-1:0]  ras_ptr, ras_ptr_d, top_idx;
    logic [NPHASE-1:0] phase_d;
    logic [PC_W-1:0]   pc_d, target;
    logic [CNT_W-1:0]  cnt_d;
    logic              we_d, err_d, halt_d, push;
    logic [4:0]        opcode;
    logic              unused_bits;

    assign opcode      = instr[15:11];
    assign target      = result[PC_W-1:0];
    assign unused_bits = ^{instr[10:0], result};

    // ras_ptr is the next push slot; when full it also points at the oldest entry.
    assign top_idx = (ras_ptr == '0) ? PTR_W'(RAS_DEPTH - 1) : ras_ptr - 1'b1;

    always_comb begin
        phase_d   = phase;
        pc_d      = pc;
        we_d      = 1'b0;
        cnt_d     = ras_count;
        ras_ptr_d = ras_ptr;
        err_d     = ras_err;
        halt_d    = halted;
        push      = 1'b0;
        if (!stall && !halted) begin
            phase_d = {phase[NPHASE-2:0], phase[NPHASE-1]};
            if (phase[0]) begin
                pc_d = pc + 1'b1;
                we_d = 1'b1;
            end else if (phase[NPHASE-1]) begin
                case (opcode)
                    OP_JMP, OP_JR: begin
                        pc_d = target;
                        we_d = 1'b1;
                    end
                    OP_BC: begin
                        if (cond) begin
                            pc_d = target;
                            we_d = 1'b1;
                        end
                    end
                    OP_CALL: begin
                        push      = 1'b1;
                        pc_d      = target;
                        we_d      = 1'b1;
                        ras_ptr_d = (ras_ptr == PTR_W'(RAS_DEPTH - 1)) ? '0 : ras_ptr + 1'b1;
                        if (ras_count == CNT_W'(RAS_DEPTH)) err_d = 1'b1;
                        else                                cnt_d = ras_count + 1'b1;
                    end
                    OP_RET: begin
                        if (ras_count != '0) begin
                            pc_d      = ras_mem[top_idx];
                            we_d      = 1'b1;
                            ras_ptr_d = top_idx;
                            cnt_d     = ras_count - 1'b1;
                        end else begin
                            err_d = 1'b1;
                        end
                    end
                    OP_HLT:  halt_d = 1'b1;
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase     <= NPHASE'(1);
            pc        <= PC_W'(RESET_PC);
            pc_we     <= 1'b0;
            ras_count <= '0;
            ras_ptr   <= '0;
            ras_err   <= 1'b0;
            halted    <= 1'b0;
        end else begin
            phase     <= phase_d;
            pc        <= pc_d;
            pc_we     <= we_d;
            ras_count <= cnt_d;
            ras_ptr   <= ras_ptr_d;
            ras_err   <= err_d;
            halted    <= halt_d;
        end
    end

    // Stack contents need no reset; ras_count alone says which entries are valid.
    always_ff @(posedge clk) begin
        if (push) ras_mem[ras_ptr] <= pc;
    end
endmodule

// File: tb/tb_pc_sequencer.sv
// Bench for pc_sequencer: directed scenarios plus random instruction streams,
// each cycle compared against a queue-based behavioural model.
module tb_pc_sequencer;
    localparam int PC_W = 12, DATA_W = 16, NPHASE = 5, RAS_DEPTH = 4, RESET_PC = 0;
    localparam logic [4:0] NOP = 5'd0, JMP = 5'b10100, BC = 5'b10101, CALL = 5'b10110;
    localparam logic [4:0] JR = 5'b10111, RET = 5'b11000, HLT = 5'b11111;

    logic clk = 1'b0, rst_n = 1'b0, stall = 1'b0, cond = 1'b0;
    logic [15:0] instr = '0;
    logic [DATA_W-1:0] result = '0;
    logic [NPHASE-1:0] phase;
    logic [PC_W-1:0] pc;
    logic pc_we, ras_err, halted;
    logic [$clog2(RAS_DEPTH+1)-1:0] ras_count;

    pc_sequencer #(.PC_W(PC_W), .DATA_W(DATA_W), .NPHASE(NPHASE),
                   .RAS_DEPTH(RAS_DEPTH), .RESET_PC(RESET_PC)) dut (
        .clk(clk), .rst_n(rst_n), .stall(stall), .instr(instr), .result(result),
        .cond(cond), .phase(phase), .pc(pc), .pc_we(pc_we), .ras_count(ras_count),
        .ras_err(ras_err), .halted(halted));

    always #5 clk = ~clk;

    // Reference model: phase index, PC, return stack as a queue (back = top).
    int checks = 0, errors = 0;
    int m_ph;
    logic [PC_W-1:0] m_pc;
    logic [PC_W-1:0] m_ras[$];
    logic m_we, m_err, m_halt;
    logic [PC_W-1:0] exp_q[$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_ph = 0; m_pc = PC_W'(RESET_PC); m_we = 0; m_err = 0; m_halt = 0;
        m_ras.delete(); exp_q.delete();
    endtask

    task automatic model_step();
        logic [4:0] op;
        logic [PC_W-1:0] tgt;
        op = instr[15:11];
        tgt = result[PC_W-1:0];
        m_we = 0;
        if (!stall && !m_halt) begin
            if (m_ph == 0) begin
                m_pc = m_pc + 1'b1;
                m_we = 1;
            end else if (m_ph == NPHASE - 1) begin
                if (op == JMP || op == JR || (op == BC && cond)) begin
                    m_pc = tgt; m_we = 1;
                end else if (op == CALL) begin
                    m_ras.push_back(m_pc);
                    if (m_ras.size() > RAS_DEPTH) begin
                        void'(m_ras.pop_front());
                        m_err = 1;
                    end
                    m_pc = tgt; m_we = 1;
                end else if (op == RET) begin
                    if (m_ras.size() > 0) begin
                        m_pc = m_ras.pop_back(); m_we = 1;
                    end else m_err = 1;
                end else if (op == HLT) m_halt = 1;
            end
            m_ph = (m_ph + 1) % NPHASE;
        end
        if (m_we) exp_q.push_back(m_pc);
    endtask

    task automatic check_all();
        chk("phase", 32'(phase), 32'(1) << m_ph);
        chk("pc", 32'(pc), 32'(m_pc));
        chk("pc_we", 32'(pc_we), 32'(m_we));
        chk("ras_count", 32'(ras_count), 32'(m_ras.size()));
        chk("ras_err", 32'(ras_err), 32'(m_err));
        chk("halted", 32'(halted), 32'(m_halt));
        if (pc_we) begin
            if (exp_q.size() > 0) chk("pc_write", 32'(pc), 32'(exp_q.pop_front()));
            else chk("pc_write_pending", 32'(exp_q.size()), 32'(1));
        end
    endtask

    // Drive one cycle's inputs at the falling edge, then check after the next edge.
    task automatic cycle(input logic s, input logic [4:0] op, input logic [15:0] r, input logic c);
        stall = s; instr = {op, 11'($urandom)}; result = r; cond = c;
        model_step();
        @(negedge clk);
        check_all();
    endtask

    task automatic run_instr(input logic [4:0] op, input logic [15:0] r, input logic c);
        repeat (NPHASE) cycle(1'b0, op, r, c);
    endtask

    task automatic do_reset();
        #2 rst_n = 1'b0;
        #1 model_reset();
        chk("areset_phase", 32'(phase), 32'(1));
        chk("areset_pc", 32'(pc), 32'(RESET_PC));
        chk("areset_cnt", 32'(ras_count), 32'(0));
        check_all();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    logic [PC_W-1:0] ret_exp [4] = '{12'h401, 12'h301, 12'h201, 12'h101};
    logic [4:0] op_tab [11] = '{CALL, CALL, CALL, RET, RET, RET, BC, BC, JMP, JR, HLT};

    initial begin
        model_reset();
        @(negedge clk);
        check_all();
        rst_n = 1'b1;

        repeat (3) run_instr(NOP, 16'h0, 1'b0);
        chk("seq_pc", 32'(pc), 32'h3);
        run_instr(JMP, 16'h0ABC, 1'b0);
        chk("jmp_target", 32'(pc), 32'hABC);
        run_instr(NOP, 16'h0, 1'b0);
        chk("jmp_fetch", 32'(pc), 32'hABD);
        run_instr(BC, 16'h0123, 1'b0);
        chk("bc_not_taken", 32'(pc), 32'hABE);
        run_instr(BC, 16'h0040, 1'b1);
        chk("bc_taken", 32'(pc), 32'h040);

        for (int k = 1; k <= 5; k++) run_instr(CALL, 16'(k * 16'h0100), 1'b0);
        chk("ras_full_cnt", 32'(ras_count), 32'd4);
        chk("ras_ovf_err", 32'(ras_err), 32'd1);
        chk("call_pc", 32'(pc), 32'h500);
        for (int k = 0; k < 4; k++) begin
            run_instr(RET, 16'($urandom), 1'b0);
            chk("ret_lifo", 32'(pc), 32'(ret_exp[k]));
        end
        run_instr(RET, 16'h0, 1'b0);
        chk("ret_empty_pc", 32'(pc), 32'h102);
        chk("ret_empty_we", 32'(pc_we), 32'd0);

        cycle(1'b0, NOP, 16'h0, 1'b0);
        cycle(1'b0, NOP, 16'h0, 1'b0);
        repeat (3) begin
            cycle(1'b1, CALL, 16'h0777, 1'b0);
            chk("stall_phase", 32'(phase), 32'h4);
            chk("stall_pc", 32'(pc), 32'h103);
        end
        repeat (3) cycle(1'b0, NOP, 16'h0, 1'b0);
        chk("stall_resume", 32'(phase), 32'h1);

        run_instr(JMP, 16'hAFFF, 1'b0);
        chk("wrap_pre", 32'(pc), 32'hFFF);
        run_instr(NOP, 16'h0, 1'b0);
        chk("wrap_pc", 32'(pc), 32'h000);

        run_instr(CALL, 16'h0200, 1'b0);
        run_instr(CALL, 16'h0300, 1'b0);
        cycle(1'b0, NOP, 16'h0, 1'b0);
        cycle(1'b0, NOP, 16'h0, 1'b0);
        chk("pre_reset_cnt", 32'(ras_count), 32'd2);
        chk("pre_reset_phase", 32'(phase), 32'h4);
        do_reset();

        run_instr(NOP, 16'h0, 1'b0);
        run_instr(HLT, 16'h0, 1'b0);
        chk("halted", 32'(halted), 32'd1);
        repeat (20) begin
            cycle(1'($urandom), op_tab[$urandom_range(0, 10)], 16'($urandom), 1'($urandom));
            chk("halt_pc", 32'(pc), 32'h2);
            chk("halt_phase", 32'(phase), 32'h1);
        end
        do_reset();

        for (int n = 0; n < 800; n++) begin
            if ((m_halt && $urandom_range(0, 7) == 0) || $urandom_range(0, 299) == 0)
                do_reset();
            else if ($urandom_range(0, 3) == 0)
                cycle($urandom_range(0, 9) == 0, 5'($urandom), 16'($urandom), 1'($urandom));
            else
                cycle($urandom_range(0, 9) == 0, op_tab[$urandom_range(0, 10)],
                      16'($urandom), 1'($urandom));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
